apb_master_bridge: RTL
======================

Name: apb_master_bridge

Overview:
- Sits directly downstream of the RV32I core's data-bus port and converts the core's request into APB transfers to peripheral slaves (RAM, GPO, GPI, UART, ...).
- Registers the core's request, decodes the address to one-hot slave selects and runs the APB SETUP/ACCESS protocol.
- Returns read data and a one-cycle ready strobe to the core.
- The core must hold off its next bus access until ready.

Parameters:
- NUM_SLV, 4, number of APB slaves (1..8); width of PSEL/PREADY, PRDATA is NUM_SLV*32.
- BASE_ADDR, 32'h1000_0000, peripheral region base; only BASE_ADDR[31:16] is compared.

Ports:
- clk  input  1  system clock, all logic on rising edge
- reset  input  1  synchronous, active-low reset
- transfer  input  1  core request strobe, sampled only in IDLE
- write  input  1  1=write, 0=read (core busWe)
- addr  input  32  byte address (core busAddr)
- wdata  input  32  write data (core busWData)
- wstrb  input  4  byte enables (core Byte_Enable)
- rdata  output  32  read data to core, valid when ready=1
- ready  output  1  one-cycle transfer-complete strobe
- slverr  output  1  decode error, valid when ready=1
- PADDR  output  32  latched address
- PWRITE  output  1  latched direction
- PWDATA  output  32  latched write data
- PSTRB  output  4  latched byte enables; driven 4'b0000 on reads
- PENABLE  output  1  APB enable
- PSEL  output  NUM_SLV  one-hot slave select
- PRDATA  input  NUM_SLV*32  slave read data, slave i at bits [32i+31:32i]
- PREADY  input  NUM_SLV  slave ready

Behaviour:
- Reset (reset=0 at a rising edge):
  - FSM goes to IDLE.
  - PADDR, PWDATA, PWRITE, PSTRB and the latched decode are cleared.
  - PSEL=0, PENABLE=0, ready=0, rdata=0, slverr=0.
  - Reset has priority over everything. Reset during SETUP or ACCESS aborts the transfer: no ready pulse, and PSEL/PENABLE are 0 from the next edge.
- FSM states: IDLE, SETUP, ACCESS.
- IDLE:
  - PSEL=0, PENABLE=0.
  - If transfer=1, latch addr/write/wdata/wstrb into the P* registers and decode into sel_q, then go to SETUP.
  - If transfer=0, stay in IDLE.
- SETUP (exactly one cycle):
  - PSEL=sel_q, PENABLE=0.
  - Always go to ACCESS.
- ACCESS:
  - PSEL=sel_q, PENABLE=1.
  - If sel_q has one bit i set: wait until PREADY[i]=1. In that cycle, ready=1, rdata=PRDATA[i] (0 on writes), slverr=0, and the next state is IDLE.
  - If sel_q is all zero (decode miss): ready=1 in the first ACCESS cycle, rdata=0, slverr=1, next state IDLE. No PSEL is asserted during the SETUP or ACCESS cycles of a missed transfer.
  - PREADY of non-selected slaves is ignored.
  - The P* outputs stay stable through SETUP and ACCESS.
- Outputs ready, rdata and slverr are combinational from state, sel_q, PREADY and PRDATA. They are 0 whenever the state is not ACCESS or the completion condition is false.
- Decode:
  - Slave i is selected when addr[31:16]==BASE_ADDR[31:16], addr[15:12]==i and i<NUM_SLV.
  - Anything else is a miss.
- Latency: transfer is accepted in cycle 0 (IDLE), SETUP is cycle 1, ACCESS is cycle 2. The earliest ready is cycle 2 (zero-wait slave); each slave wait state adds one cycle.
- transfer asserted in SETUP or ACCESS is ignored. The core must re-present the request in IDLE. Transfers are back-to-back at best 3 cycles apart: ready in cycle 2, IDLE in cycle 3 accepts the next request.
- There is no timeout: a slave that never raises PREADY stalls the bridge until reset.

Test Plan:
- Write to slave 1:
  - Stimulus: reset=0 for 2 cycles, then transfer=1, write=1, addr=0x1000_1004, wdata=0xDEAD_BEEF, wstrb=4'b1111; PREADY[1]=1.
  - Response: cycle 1 PSEL=4'b0010, PENABLE=0, PADDR=0x1000_1004. Cycle 2 PENABLE=1, ready=1, slverr=0. Cycle 3 PSEL=0.
- Read from slave 0 with 2 wait states:
  - Stimulus: addr=0x1000_0008, write=0; PREADY[0] low for 2 ACCESS cycles; PRDATA0=0x1234_5678.
  - Response: PSTRB=0. ready=1 only in cycle 4, with rdata=0x1234_5678.
- Decode miss:
  - Stimulus: addr=0x2000_0000 read.
  - Response: PSEL stays 0 throughout. Cycle 2 ready=1, slverr=1, rdata=0.
- Ignored request:
  - Stimulus: transfer held high through SETUP/ACCESS with addr changing to 0x1000_2000.
  - Response: PADDR stays at the first address. Exactly one ready pulse for the first request; a second transfer starts only after IDLE.
- Reset mid-ACCESS:
  - Stimulus: reset=0 while PENABLE=1 and PREADY=0.
  - Response: next cycle PSEL=0, PENABLE=0, ready=0, state IDLE. A new request after reset completes normally.
- Byte write:
  - Stimulus: wstrb=4'b0100, addr=0x1000_3002, wdata=0x00AB_0000; PREADY[3]=1.
  - Response: PSEL=4'b1000, PSTRB=4'b0100, PWDATA=0x00AB_0000 through SETUP and ACCESS.

Source files
------------

// File: rtl/apb_master_bridge.sv
// apb_master_bridge: turns a single core data-bus request into one APB transfer.
// The request is registered in IDLE, decoded to a one-hot slave select, then
// driven through the SETUP and ACCESS phases. A one-cycle ready strobe returns
// read data, or a decode error, to the core.
module apb_master_bridge #(
   parameter int          NUM_SLV   = 4,
   parameter logic [31:0] BASE_ADDR = 32'h1000_0000
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   transfer,
   input  logic                   write,
   input  logic [31:0]            addr,
   input  logic [31:0]            wdata,
   input  logic [3:0]             wstrb,
   output logic [31:0]            rdata,
   output logic                   ready,
   output logic                   slverr,
   output logic [31:0]            PADDR,
   output logic                   PWRITE,
   output logic [31:0]            PWDATA,
   output logic [3:0]             PSTRB,
   output logic                   PENABLE,
   output logic [NUM_SLV-1:0]     PSEL,
   input  logic [NUM_SLV*32-1:0]  PRDATA,
   input  logic [NUM_SLV-1:0]     PREADY
);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SETUP  = 2'd1,
      ACCESS = 2'd2
   } state_t;

   state_t              state_reg;
   state_t              state_next;
   logic [NUM_SLV-1:0]  sel_reg;
   logic [NUM_SLV-1:0]  addr_dec;
   logic [NUM_SLV-1:0]  slv_done;
   logic [31:0]         slv_rdata [NUM_SLV];
   logic [31:0]         rdata_mux;

   // Per-slave address decode, completion detect and masked read data.
   // Slave i owns the 4 KB window BASE_ADDR[31:16] : i : xxx.
   generate
      for (genvar gi = 0; gi < NUM_SLV; gi++) begin : g_slv
         assign addr_dec[gi]  = (addr[31:16] == BASE_ADDR[31:16]) &&
                                (addr[15:12] == 4'(gi));
         assign slv_done[gi]  = sel_reg[gi] & PREADY[gi];
         assign slv_rdata[gi] = sel_reg[gi] ? PRDATA[32*gi +: 32] : 32'h0;
      end
   endgenerate

   // OR together the masked slave read buses; at most one is non-zero.
   always_comb begin
      rdata_mux = 32'h0;
      for (int i = 0; i < NUM_SLV; i++) begin
         rdata_mux = rdata_mux | slv_rdata[i];
      end
   end

   // FSM state register; reset aborts any transfer in flight.
   always_ff @(posedge clk) begin
      if (!reset) begin
         state_reg <= IDLE;
      end else begin
         state_reg <= state_next;
      end
   end

   // Capture the core request in IDLE; held stable through SETUP and ACCESS.
   always_ff @(posedge clk) begin
      if (!reset) begin
         PADDR   <= 32'h0;
         PWRITE  <= 1'b0;
         PWDATA  <= 32'h0;
         PSTRB   <= 4'b0000;
         sel_reg <= '0;
      end else if (state_reg == IDLE && transfer) begin
         PADDR   <= addr;
         PWRITE  <= write;
         PWDATA  <= wdata;
         PSTRB   <= write ? wstrb : 4'b0000;
         sel_reg <= addr_dec;
      end
   end

   // Next-state and APB/core handshake outputs.
   always_comb begin
      state_next = state_reg;
      PSEL       = '0;
      PENABLE    = 1'b0;
      ready      = 1'b0;
      rdata      = 32'h0;
      slverr     = 1'b0;
      case (state_reg)
         IDLE: begin
            if (transfer) begin
               state_next = SETUP;
            end
         end
         SETUP: begin
            PSEL       = sel_reg;
            state_next = ACCESS;
         end
         ACCESS: begin
            PSEL    = sel_reg;
            PENABLE = 1'b1;
            if (sel_reg == '0) begin
               // Decode miss: complete immediately with an error, no slave involved.
               ready      = 1'b1;
               slverr     = 1'b1;
               state_next = IDLE;
            end else if (|slv_done) begin
               ready      = 1'b1;
               rdata      = PWRITE ? 32'h0 : rdata_mux;
               state_next = IDLE;
            end
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

endmodule
